// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte stream among N_REQ requesters.
// A stalled owner is released after TIMEOUT cycles in LOCK without a transfer.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = TMO_EN ? CW'(TIMEOUT - 1) : {CW{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state_r;
    logic [PW-1:0]    owner_r;
    logic [PW-1:0]    rr_ptr_r;
    logic [N_REQ-1:0] grant_r;
    logic [CW-1:0]    idle_cnt_r;
    logic             timeout_r;

    logic [PW-1:0]    win_s;
    logic             win_found_s;
    logic [PW-1:0]    idx_s;
    logic             tx_valid_s;
    logic             xfer_s;
    logic             last_s;
    logic             tmo_hit_s;

    // Round-robin winner: first valid requester after rr_ptr, wrapping
    always_comb begin
        win_s       = rr_ptr_r;
        win_found_s = 1'b0;
        idx_s       = {PW{1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = PW'((32'(rr_ptr_r) + 32'(i)) % 32'(N_REQ));
            if (!win_found_s && req_valid_i[idx_s]) begin
                win_s       = idx_s;
                win_found_s = 1'b1;
            end else begin
                win_s       = win_s;
                win_found_s = win_found_s;
            end
        end
    end

    // Owner passthrough; nothing is handed over during a reset cycle
    always_comb begin
        tx_valid_s  = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = {N_REQ{1'b0}};
        if ((state_r == ST_LOCK) && !rst_i) begin
            tx_valid_s  = req_valid_i[owner_r];
            tx_data_o   = req_data_i[{owner_r, 3'b000} +: 8];
            req_ready_o = grant_r & {N_REQ{tx_ready_i}};
        end else begin
            tx_valid_s  = 1'b0;
            tx_data_o   = 8'h00;
            req_ready_o = {N_REQ{1'b0}};
        end
    end

    assign tx_valid_o = tx_valid_s;
    assign xfer_s     = tx_valid_s & tx_ready_i;
    assign last_s     = req_last_i[owner_r];
    // A transfer in the expiring cycle takes precedence over the timeout
    assign tmo_hit_s  = TMO_EN && (state_r == ST_LOCK) && (idle_cnt_r == CNT_LAST) && !xfer_s;

    // Arbitration FSM, grant lock, idle counter and timeout pulse
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            owner_r    <= {PW{1'b0}};
            rr_ptr_r   <= PW'(N_REQ - 1);
            grant_r    <= {N_REQ{1'b0}};
            idle_cnt_r <= {CW{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enable_i && win_found_s) begin
                        state_r    <= ST_LOCK;
                        owner_r    <= win_s;
                        grant_r    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
                        idle_cnt_r <= {CW{1'b0}};
                    end
                end
                ST_LOCK: begin
                    if (xfer_s && last_s) begin
                        state_r  <= ST_IDLE;
                        grant_r  <= {N_REQ{1'b0}};
                        rr_ptr_r <= owner_r;
                    end else if (tmo_hit_s) begin
                        state_r   <= ST_IDLE;
                        grant_r   <= {N_REQ{1'b0}};
                        rr_ptr_r  <= owner_r;
                        timeout_r <= 1'b1;
                    end else if (xfer_s) begin
                        idle_cnt_r <= {CW{1'b0}};
                    end else if (idle_cnt_r != CNT_MAX) begin
                        idle_cnt_r <= idle_cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign grant_o   = grant_r;
    assign busy_o    = (state_r == ST_LOCK);
    assign timeout_o = timeout_r;

endmodule
